hermes_router_mlp: RTL and testbench

//  Parametrised Hermes mesh router: 4 mesh ports (E,W,N,S) plus LOCAL_PORTS local ports.

---
 rtl/hermes_router_mlp_pkg.sv | 23 ++
 rtl/hermes_credit_fifo.sv | 51 +++++
 rtl/hermes_router_mlp.sv | 214 +++++++++++++++++++++
 tb/tb_hermes_router_mlp.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/hermes_router_mlp_pkg.sv
// Shared definitions for the Hermes mesh router: port indices, header layout and input FSM states.
package hermes_router_mlp_pkg;

  localparam int HERMES_EAST   = 0;
  localparam int HERMES_WEST   = 1;
  localparam int HERMES_NORTH  = 2;
  localparam int HERMES_SOUTH  = 3;
  localparam int HERMES_LOCAL0 = 4;

  localparam int HDR_Y_LSB   = 0;
  localparam int HDR_X_LSB   = 8;
  localparam int HDR_COORD_W = 8;
  localparam int HDR_L_LSB   = 16;
  localparam int HDR_L_W     = 2;

  typedef enum logic [1:0] {
    IN_IDLE,
    IN_REQ,
    IN_FWD_SIZE,
    IN_FWD_PAY
  } hermes_in_state_t;

endpackage

// File: rtl/hermes_credit_fifo.sv
// Per-input flit FIFO; credit_o is a registered "not full" flag derived from next occupancy.
module hermes_credit_fifo #(
  parameter int BUFFER_SIZE = 8,
  parameter int FLIT_SIZE   = 32
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 wr_i,
  input  logic [FLIT_SIZE-1:0] data_i,
  input  logic                 rd_i,
  output logic [FLIT_SIZE-1:0] data_o,
  output logic                 empty_o,
  output logic                 credit_o
);
  import hermes_router_mlp_pkg::*;

  localparam int AW = $clog2(BUFFER_SIZE);

  logic [FLIT_SIZE-1:0] mem_q [BUFFER_SIZE];
  logic [AW-1:0]        wr_ptr_q, rd_ptr_q;
  logic [AW:0]          cnt_q, cnt_d;
  logic                 credit_q;
  logic                 wr_en, rd_en;

  // Writes while full are dropped: the upstream side must honour credit.
  assign wr_en   = wr_i & credit_q;
  assign rd_en   = rd_i & (cnt_q != '0);
  assign cnt_d   = cnt_q + (AW+1)'(wr_en) - (AW+1)'(rd_en);
  assign data_o  = mem_q[rd_ptr_q];
  assign empty_o = (cnt_q == '0);
  assign credit_o = credit_q;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      credit_q <= 1'b1;
    end else begin
      if (wr_en) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (rd_en) rd_ptr_q <= rd_ptr_q + AW'(1);
      cnt_q    <= cnt_d;
      credit_q <= (cnt_d != (AW+1)'(BUFFER_SIZE));
    end
  end

  always_ff @(posedge clk_i) begin
    if (wr_en) mem_q[wr_ptr_q] <= data_i;
  end

endmodule

// File: rtl/hermes_router_mlp.sv
// Hermes mesh router: credit FIFOs, round-robin XY arbiter with local-port select, crossbar.
// Optional per-output packet counters enabled by defining HERMES_ROUTER_STATS_EN.
module hermes_router_mlp
  import hermes_router_mlp_pkg::*;
#(
  parameter logic [15:0] ADDRESS     = 16'h0000,
  parameter int          LOCAL_PORTS = 2,
  parameter int          BUFFER_SIZE = 8,
  parameter int          FLIT_SIZE   = 32,
  localparam int         NPORT       = 4 + LOCAL_PORTS
) (
  input  logic                            clk_i,
  input  logic                            rst_ni,
  input  logic [NPORT-1:0]                rx_i,
  input  logic [NPORT-1:0][FLIT_SIZE-1:0] data_i,
  output logic [NPORT-1:0]                credit_o,
  output logic [NPORT-1:0]                tx_o,
  output logic [NPORT-1:0][FLIT_SIZE-1:0] data_o,
  input  logic [NPORT-1:0]                credit_i
`ifdef HERMES_ROUTER_STATS_EN
  ,
  output logic [NPORT-1:0][31:0]          pkt_cnt_o
`endif
);

  localparam int PW = $clog2(NPORT);

  logic [NPORT-1:0][FLIT_SIZE-1:0] head;
  logic [NPORT-1:0]                empty;
  logic [NPORT-1:0]                rd;

  hermes_in_state_t     state_q [NPORT];
  hermes_in_state_t     state_d [NPORT];
  logic                 hdr_pend_q [NPORT];
  logic                 hdr_pend_d [NPORT];
  logic [FLIT_SIZE-1:0] cnt_q [NPORT];
  logic [FLIT_SIZE-1:0] cnt_d [NPORT];
  logic [PW-1:0]        sel_q [NPORT];
  logic [PW-1:0]        sel_d [NPORT];
  logic [PW-1:0]        src_q [NPORT];
  logic [PW-1:0]        src_d [NPORT];
  logic [NPORT-1:0]     busy_q, busy_d;
  logic [PW-1:0]        rr_q, rr_d;

  logic                 found;
  logic [PW-1:0]        pick;
  logic [PW-1:0]        pick_tgt;
  logic                 grant;

  for (genvar g = 0; g < NPORT; g++) begin : g_in
    hermes_credit_fifo #(
      .BUFFER_SIZE(BUFFER_SIZE),
      .FLIT_SIZE  (FLIT_SIZE)
    ) u_fifo (
      .clk_i   (clk_i),
      .rst_ni  (rst_ni),
      .wr_i    (rx_i[g]),
      .data_i  (data_i[g]),
      .rd_i    (rd[g]),
      .data_o  (head[g]),
      .empty_o (empty[g]),
      .credit_o(credit_o[g])
    );
  end

  // XY routing; an out-of-range local index falls back to LOCAL0.
  function automatic logic [PW-1:0] route(input logic [17:0] hdr);
    logic [HDR_COORD_W-1:0] tx, ty, mx, my;
    logic [HDR_L_W-1:0]     l;
    tx = hdr[HDR_X_LSB +: HDR_COORD_W];
    ty = hdr[HDR_Y_LSB +: HDR_COORD_W];
    l  = hdr[HDR_L_LSB +: HDR_L_W];
    mx = ADDRESS[15:8];
    my = ADDRESS[7:0];
    if (tx > mx)                     return PW'(HERMES_EAST);
    else if (tx < mx)                return PW'(HERMES_WEST);
    else if (ty > my)                return PW'(HERMES_NORTH);
    else if (ty < my)                return PW'(HERMES_SOUTH);
    else if (int'(l) >= LOCAL_PORTS) return PW'(HERMES_LOCAL0);
    else                             return PW'(HERMES_LOCAL0 + int'(l));
  endfunction

  always_comb begin
    int idx;
    found = 1'b0;
    pick  = '0;
    idx   = 0;
    for (int k = 0; k < NPORT; k++) begin
      idx = (int'(rr_q) + k) % NPORT;
      if (!found && state_q[idx] == IN_REQ) begin
        found = 1'b1;
        pick  = PW'(idx);
      end
    end
    pick_tgt = route(head[pick][17:0]);
    grant    = found && !busy_q[pick_tgt];
  end

  always_comb begin
    for (int i = 0; i < NPORT; i++) begin
      rd[i] = (state_q[i] == IN_FWD_SIZE || state_q[i] == IN_FWD_PAY) &&
              !empty[i] && credit_i[sel_q[i]];
    end
  end

  // Crossbar: a busy output mirrors the head of the input it is connected to.
  always_comb begin
    for (int o = 0; o < NPORT; o++) begin
      tx_o[o]   = 1'b0;
      data_o[o] = '0;
      if (busy_q[o]) begin
        tx_o[o]   = !empty[src_q[o]];
        data_o[o] = head[src_q[o]];
      end
    end
  end

  always_comb begin
    busy_d = busy_q;
    rr_d   = rr_q;
    for (int i = 0; i < NPORT; i++) begin
      state_d[i]    = state_q[i];
      hdr_pend_d[i] = hdr_pend_q[i];
      cnt_d[i]      = cnt_q[i];
      sel_d[i]      = sel_q[i];
      src_d[i]      = src_q[i];
    end
    if (found) rr_d = (pick == PW'(NPORT-1)) ? '0 : pick + PW'(1);
    for (int i = 0; i < NPORT; i++) begin
      case (state_q[i])
        IN_IDLE: if (!empty[i]) state_d[i] = IN_REQ;
        IN_REQ: begin
          if (grant && pick == PW'(i)) begin
            state_d[i]    = IN_FWD_SIZE;
            hdr_pend_d[i] = 1'b1;
            sel_d[i]      = pick_tgt;
          end
        end
        IN_FWD_SIZE: begin
          if (rd[i]) begin
            if (hdr_pend_q[i]) begin
              hdr_pend_d[i] = 1'b0;
            end else if (head[i] == '0) begin
              state_d[i]         = IN_IDLE;
              busy_d[sel_q[i]]   = 1'b0;
            end else begin
              cnt_d[i]   = head[i];
              state_d[i] = IN_FWD_PAY;
            end
          end
        end
        IN_FWD_PAY: begin
          if (rd[i]) begin
            cnt_d[i] = cnt_q[i] - FLIT_SIZE'(1);
            if (cnt_q[i] == FLIT_SIZE'(1)) begin
              state_d[i]       = IN_IDLE;
              busy_d[sel_q[i]] = 1'b0;
            end
          end
        end
        default: state_d[i] = IN_IDLE;
      endcase
    end
    // A granted output is never the one being released this cycle (release needs busy).
    if (grant) begin
      busy_d[pick_tgt] = 1'b1;
      src_d[pick_tgt]  = pick;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      busy_q <= '0;
      rr_q   <= '0;
      for (int i = 0; i < NPORT; i++) begin
        state_q[i]    <= IN_IDLE;
        hdr_pend_q[i] <= 1'b0;
      end
    end else begin
      busy_q <= busy_d;
      rr_q   <= rr_d;
      for (int i = 0; i < NPORT; i++) begin
        state_q[i]    <= state_d[i];
        hdr_pend_q[i] <= hdr_pend_d[i];
      end
    end
  end

  always_ff @(posedge clk_i) begin
    for (int i = 0; i < NPORT; i++) begin
      cnt_q[i] <= cnt_d[i];
      sel_q[i] <= sel_d[i];
      src_q[i] <= src_d[i];
    end
  end

`ifdef HERMES_ROUTER_STATS_EN
  logic [NPORT-1:0][31:0] pkt_cnt_q;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      pkt_cnt_q <= '0;
    end else begin
      for (int i = 0; i < NPORT; i++) begin
        if (rd[i] && state_q[i] == IN_FWD_SIZE && hdr_pend_q[i])
          pkt_cnt_q[sel_q[i]] <= pkt_cnt_q[sel_q[i]] + 32'd1;
      end
    end
  end

  assign pkt_cnt_o = pkt_cnt_q;
`endif

endmodule

// File: tb/tb_hermes_router_mlp.sv
// Scoreboard bench for hermes_router_mlp at node (1,1) with two local ports.
module tb_hermes_router_mlp;

  localparam int NP = 6;
  localparam int FW = 32;
  localparam int E = 0, W = 1, N = 2, S = 3, L0 = 4, L1 = 5;

  logic                   clk = 1'b0;
  logic                   rst_n;
  logic [NP-1:0]          rx, credit_out, tx, credit_in;
  logic [NP-1:0][FW-1:0]  din, dout;
`ifdef HERMES_ROUTER_STATS_EN
  logic [NP-1:0][31:0]    pkt_cnt;
`endif

  always #5 clk = ~clk;

  hermes_router_mlp #(
    .ADDRESS    (16'h0101),
    .LOCAL_PORTS(2),
    .BUFFER_SIZE(8),
    .FLIT_SIZE  (FW)
  ) dut (
    .clk_i    (clk),
    .rst_ni   (rst_n),
    .rx_i     (rx),
    .data_i   (din),
    .credit_o (credit_out),
    .tx_o     (tx),
    .data_o   (dout),
    .credit_i (credit_in)
`ifdef HERMES_ROUTER_STATS_EN
    ,
    .pkt_cnt_o(pkt_cnt)
`endif
  );

  int checks = 0;
  int errors = 0;
  logic [FW-1:0] exp_q [NP][$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Monitor: every accepted output flit must match the head of that output's queue.
  always @(negedge clk) begin
    if (rst_n) begin
      for (int o = 0; o < NP; o++) begin
        if (tx[o] && credit_in[o]) begin
          logic [FW-1:0] e;
          checks++;
          if (exp_q[o].size() == 0) begin
            errors++;
            $display("FAIL out%0d_unexpected actual=%0h required=none", o, dout[o]);
          end else begin
            e = exp_q[o].pop_front();
            if (dout[o] !== e) begin
              errors++;
              $display("FAIL out%0d_flit actual=%0h required=%0h", o, dout[o], e);
            end
          end
        end
      end
    end
  end

  task automatic send_flit(input int p, input logic [FW-1:0] d);
    int guard = 0;
    while (!credit_out[p]) begin
      @(posedge clk); #1;
      guard++;
      if (guard > 500) begin
        $display("FAIL credit_wait port%0d actual=0 required=1", p);
        $fatal(1, "credit never returned");
      end
    end
    rx[p]  = 1'b1;
    din[p] = d;
    @(posedge clk); #1;
    rx[p]  = 1'b0;
  endtask

  task automatic send_pkt(input int p, input logic [FW-1:0] hdr, input int sz, input logic [FW-1:0] base);
    send_flit(p, hdr);
    send_flit(p, FW'(sz));
    for (int k = 0; k < sz; k++) send_flit(p, base + FW'(k));
  endtask

  task automatic push_pkt(input int o, input logic [FW-1:0] hdr, input int sz, input logic [FW-1:0] base);
    exp_q[o].push_back(hdr);
    exp_q[o].push_back(FW'(sz));
    for (int k = 0; k < sz; k++) exp_q[o].push_back(base + FW'(k));
  endtask

  function automatic int pending();
    int t = 0;
    for (int o = 0; o < NP; o++) t += exp_q[o].size();
    return t;
  endfunction

  task automatic wait_drain(input string name);
    int n = 0;
    while ((pending() != 0 || tx != '0) && n < 1000) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (n >= 1000) begin
      errors++;
      $display("FAIL %s_drain actual=%0d_pending required=0", name, pending());
    end
  endtask

  task automatic pulse_reset();
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  initial begin
    repeat (20000) @(posedge clk);
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n     = 1'b0;
    rx        = '0;
    din       = '0;
    credit_in = '1;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check("reset_tx", 32'(tx), 32'h0);
    check("reset_credit", 32'(credit_out), 32'h3f);
    check("reset_data_e", dout[E], 32'h0);
    @(posedge clk); #1;

    // W -> E, 3 payload flits
    push_pkt(E, 32'h0000_0301, 3, 32'hA000_0000);
    send_pkt(W, 32'h0000_0301, 3, 32'hA000_0000);
    wait_drain("t1");

    // Local selection: L=1 -> LOCAL1, L=3 -> LOCAL0
    push_pkt(L1, 32'h0001_0101, 1, 32'hB100_0000);
    push_pkt(L0, 32'h0003_0101, 1, 32'hB000_0000);
    send_pkt(N, 32'h0001_0101, 1, 32'hB100_0000);
    send_pkt(N, 32'h0003_0101, 1, 32'hB000_0000);
    wait_drain("t2");

    // Contention for E with RR pointer at 0: W wins, S follows
    pulse_reset();
    push_pkt(E, 32'h0000_0301, 2, 32'hC100_0000);
    push_pkt(E, 32'h0000_0201, 2, 32'hC300_0000);
    fork
      send_pkt(W, 32'h0000_0301, 2, 32'hC100_0000);
      send_pkt(S, 32'h0000_0201, 2, 32'hC300_0000);
    join
    wait_drain("t3");

    // Back-pressure on E mid-payload
    push_pkt(E, 32'h0000_0301, 14, 32'hD000_0000);
    fork
      send_pkt(W, 32'h0000_0301, 14, 32'hD000_0000);
      begin
        repeat (4) @(posedge clk);
        #1 credit_in[E] = 1'b0;
        repeat (10) @(posedge clk);
        @(negedge clk);
        check("t4_credit_w_full", 32'(credit_out[W]), 32'h0);
        check("t4_tx_held", 32'(tx[E]), 32'h1);
        @(posedge clk); #1;
        credit_in[E] = 1'b1;
      end
    join
    wait_drain("t4");

    // Two back-to-back zero-size packets LOCAL0 -> S
    push_pkt(S, 32'h0000_0100, 0, 32'h0);
    push_pkt(S, 32'h0000_0100, 0, 32'h0);
    send_pkt(L0, 32'h0000_0100, 0, 32'h0);
    send_pkt(L0, 32'h0000_0100, 0, 32'h0);
    wait_drain("t5");

    // Reset with a buffered, blocked packet: everything must be discarded
    credit_in[E] = 1'b0;
    send_pkt(W, 32'h0000_0301, 4, 32'hE000_0000);
    repeat (3) @(posedge clk);
    #1;
    pulse_reset();
    @(negedge clk);
    check("t6_tx", 32'(tx), 32'h0);
    check("t6_credit", 32'(credit_out), 32'h3f);
`ifdef HERMES_ROUTER_STATS_EN
    check("t6_pkt_cnt_e", pkt_cnt[E], 32'h0);
`endif
    @(posedge clk); #1;
    credit_in[E] = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    push_pkt(E, 32'h0000_0301, 2, 32'hF000_0000);
    send_pkt(N, 32'h0000_0301, 2, 32'hF000_0000);
    wait_drain("t6");

    for (int o = 0; o < NP; o++)
      check($sformatf("final_queue%0d", o), 32'(exp_q[o].size()), 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
